// File: rtl/fp_cmp_pkg.sv
// Shared definitions for the floating-point compare arbiter: op codes, compare
// codes, controller states and the op-decode helper used on the response path.
package fp_cmp_pkg;

   localparam logic [2:0] FEQ  = 3'b000;
   localparam logic [2:0] FLT  = 3'b001;
   localparam logic [2:0] FLE  = 3'b010;
   localparam logic [2:0] FMIN = 3'b011;
   localparam logic [2:0] FMAX = 3'b100;

   localparam logic [1:0] CMP_EQ = 2'b00;
   localparam logic [1:0] CMP_GT = 2'b01;
   localparam logic [1:0] CMP_LT = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } cmp_resp_t;

   // Turns the compare unit's ordering code into the requested result word.
   function automatic cmp_resp_t eval_op(input logic [2:0]  op,
                                         input logic [1:0]  code,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      cmp_resp_t r;
      r = '0;
      case (op)
         FEQ:     r.data = {31'b0, (code == CMP_EQ)};
         FLT:     r.data = {31'b0, (code == CMP_LT)};
         FLE:     r.data = {31'b0, (code == CMP_EQ) || (code == CMP_LT)};
         FMIN:    r.data = ((code == CMP_EQ) || (code == CMP_LT)) ? a : b;
         FMAX:    r.data = ((code == CMP_EQ) || (code == CMP_GT)) ? a : b;
         default: r.err  = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fp_compare_arbiter_rr_arbiter.sv
// Round-robin pick: first asserted request at or above ptr, wrapping to 0.
// Purely combinational; the pointer itself lives in the controller.
module rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    grant_idx_o,
   output logic               any_o
);

   logic [ID_W-1:0] k;

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment; a path that leaves one unassigned infers a latch.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      any_o       = 1'b0;
      k           = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k = ID_W'((int'(ptr_i) + i) % NUM_REQ);
         if (!any_o && req_i[k]) begin
            any_o       = 1'b1;
            grant_idx_o = k;
            grant_o[k]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpu_cmp.sv
// FPU compare unit: raw-bit IEEE ordering of two single-precision words, no
// NaN handling, so -0 orders below +0.
module fpu_cmp
   import fp_cmp_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [1:0]  code_o
);

   always_comb begin
      code_o = CMP_EQ;
      if (a_i != b_i) begin
         if (a_i[31] != b_i[31]) begin
            code_o = a_i[31] ? CMP_LT : CMP_GT;
         end else if (!a_i[31]) begin
            code_o = (a_i[30:0] > b_i[30:0]) ? CMP_GT : CMP_LT;
         end else begin
            // Both negative: the larger magnitude is the smaller value.
            code_o = (a_i[30:0] > b_i[30:0]) ? CMP_LT : CMP_GT;
         end
      end
   end

endmodule

// File: rtl/fp_compare_arbiter.sv
// Shares the single FPU compare unit among NUM_REQ requesters: round-robin
// accept, operand capture, one compare cycle, then a held tagged response.
module fp_compare_arbiter
   import fp_cmp_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [32*NUM_REQ-1:0] req_a,
   input  logic [32*NUM_REQ-1:0] req_b,
   input  logic [3*NUM_REQ-1:0]  req_op,
   output logic [NUM_REQ-1:0]    req_ready,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [ID_W-1:0]       resp_id,
   output logic [31:0]           resp_data,
   output logic                  resp_err,
   output logic                  busy
);

   state_e          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d;
   logic [ID_W-1:0] gnt_id_q;
   logic [31:0]     a_q, b_q;
   logic [2:0]      op_q;
   logic [ID_W-1:0] resp_id_q;
   logic [31:0]     resp_data_q;
   logic            resp_err_q;

   logic               load_req;
   logic               load_resp;
   logic [NUM_REQ-1:0] arb_grant;
   logic [ID_W-1:0]    arb_idx;
   logic               arb_any;
   logic [1:0]         cmp_code;
   cmp_resp_t          cmp_res;

   logic [31:0] a_arr  [NUM_REQ];
   logic [31:0] b_arr  [NUM_REQ];
   logic [2:0]  op_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_arr[gi]  = req_a[32*gi +: 32];
      assign b_arr[gi]  = req_b[32*gi +: 32];
      assign op_arr[gi] = req_op[3*gi +: 3];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i       (req_valid),
      .ptr_i       (ptr_q),
      .grant_o     (arb_grant),
      .grant_idx_o (arb_idx),
      .any_o       (arb_any)
   );

   fpu_cmp u_cmp (
      .a_i    (a_q),
      .b_i    (b_q),
      .code_o (cmp_code)
   );

   assign cmp_res = eval_op(op_q, cmp_code, a_q, b_q);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      load_req  = 1'b0;
      load_resp = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_any) begin
               load_req = 1'b1;
               state_d  = CMP;
            end
         end
         CMP: begin
            load_resp = 1'b1;
            state_d   = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               ptr_d   = (gnt_id_q == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of the order blocks are evaluated in.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_id_q    <= '0;
         resp_id_q   <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         if (load_req) begin
            gnt_id_q <= arb_idx;
         end
         if (load_resp) begin
            resp_id_q   <= gnt_id_q;
            resp_data_q <= cmp_res.data;
            resp_err_q  <= cmp_res.err;
         end
      end
   end

   // NOTE: operand registers carry no reset; they are always loaded in the
   // accept cycle before anything reads them, so reset would only cost routing.
   always_ff @(posedge CLK) begin
      if (load_req) begin
         a_q  <= a_arr[arb_idx];
         b_q  <= b_arr[arb_idx];
         op_q <= op_arr[arb_idx];
      end
   end

   // The accept strobe marks the cycle the operands are captured, so it is
   // qualified by IDLE and reset rather than registered a cycle late.
   assign req_ready  = (state_q == IDLE && !RESET) ? arb_grant : '0;
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;

   a_ready_onehot : assert property (@(posedge CLK) disable iff (RESET)
      $onehot0(req_ready));
   a_ready_idle : assert property (@(posedge CLK) disable iff (RESET)
      (req_ready != '0) |-> (state_q == IDLE));
   a_resp_hold : assert property (@(posedge CLK) disable iff (RESET)
      (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_data) &&
                                       $stable(resp_id) && $stable(resp_err)));

endmodule

// File: tb/tb_fp_compare_arbiter.sv
// Self-checking bench for fp_compare_arbiter: directed scenarios plus random
// transactions against an ordering-key reference model.
module tb_fp_compare_arbiter;

   logic         CLK = 1'b0;
   logic         RESET;
   logic [3:0]   req_valid;
   logic [127:0] req_a;
   logic [127:0] req_b;
   logic [11:0]  req_op;
   logic [3:0]   req_ready;
   logic         resp_valid;
   logic         resp_ready;
   logic [1:0]   resp_id;
   logic [31:0]  resp_data;
   logic         resp_err;
   logic         busy;

   int errors = 0;
   int checks = 0;
   int model_ptr = 0;

   always #5 CLK = ~CLK;

   fp_compare_arbiter #(.NUM_REQ(4)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   // Map each word to an unsigned key whose natural order is IEEE bit order.
   function automatic logic [31:0] order_key(input logic [31:0] x);
      return x[31] ? ~x : (x | 32'h8000_0000);
   endfunction

   // Reference result: {err, data}.
   function automatic logic [32:0] ref_eval(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] ka, kb;
      ka = order_key(a);
      kb = order_key(b);
      case (op)
         3'd0:    return {1'b0, 31'b0, ka == kb};
         3'd1:    return {1'b0, 31'b0, ka < kb};
         3'd2:    return {1'b0, 31'b0, ka <= kb};
         3'd3:    return {1'b0, (ka <= kb) ? a : b};
         3'd4:    return {1'b0, (ka >= kb) ? a : b};
         default: return {1'b1, 32'b0};
      endcase
   endfunction

   function automatic int model_grant(input logic [3:0] v, input int p);
      for (int i = 0; i < 4; i++) begin
         if (v[(p + i) % 4]) return (p + i) % 4;
      end
      return -1;
   endfunction

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic load_slot(input int id, input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] op);
      req_a[32*id +: 32] = a;
      req_b[32*id +: 32] = b;
      req_op[3*id +: 3]  = op;
   endtask

   // One request from a lone requester; resp_ready held low for `hold` RESP cycles.
   task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input int hold, input string tag);
      logic [32:0] exp;
      int n;
      exp = ref_eval(op, a, b);
      load_slot(id, a, b, op);
      req_valid     = '0;
      req_valid[id] = 1'b1;
      resp_ready    = (hold == 0);
      #1;
      n = 0;
      while (req_ready === 4'b0 && n < 20) begin
         cyc();
         #1;
         n++;
      end
      checks++;
      if (req_ready !== (4'b0001 << id)) begin
         errors++;
         $display("FAIL %s grant: got req_ready=%b, expected %b", tag, req_ready, 4'b0001 << id);
      end
      cyc();
      req_valid = '0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL %s cmp_cycle: got resp_valid=%b req_ready=%b busy=%b, expected 0 0000 1",
                  tag, resp_valid, req_ready, busy);
      end
      cyc();
      #1;
      for (int h = 0; h <= hold; h++) begin
         if (h == hold) resp_ready = 1'b1;
         checks++;
         if (resp_valid !== 1'b1 || resp_id !== 2'(id) || resp_data !== exp[31:0] ||
             resp_err !== exp[32]) begin
            errors++;
            $display("FAIL %s resp: got v=%b id=%0d data=%h err=%b, expected v=1 id=%0d data=%h err=%b",
                     tag, resp_valid, resp_id, resp_data, resp_err, id, exp[31:0], exp[32]);
         end
         if (h < hold) begin
            cyc();
            #1;
         end
      end
      cyc();
      #1;
      model_ptr = (id + 1) % 4;
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s release: got resp_valid=%b busy=%b, expected 0 0", tag, resp_valid, busy);
      end
   endtask

   task automatic test_reset();
      RESET      = 1'b1;
      req_valid  = '0;
      req_a      = '0;
      req_b      = '0;
      req_op     = '0;
      resp_ready = 1'b0;
      cyc();
      cyc();
      req_valid = 4'hF;
      #1;
      checks++;
      if (req_ready !== 4'b0) begin
         errors++;
         $display("FAIL reset_ready_gate: got req_ready=%b, expected 0000", req_ready);
      end
      req_valid = '0;
      cyc();
      RESET = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         checks++;
         if ({req_ready, resp_valid, resp_id, resp_data, resp_err, busy} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got ready=%b v=%b id=%0d data=%h err=%b busy=%b, expected all 0",
                     req_ready, resp_valid, resp_id, resp_data, resp_err, busy);
         end
         cyc();
      end
      model_ptr = 0;
   endtask

   task automatic test_single();
      issue(2, 32'hBF80_0000, 32'h3F80_0000, 3'b001, 0, "single_flt");
   endtask

   task automatic test_minmax();
      issue(0, 32'h4040_0000, 32'h4000_0000, 3'b011, 0, "fmin_3_2");
      issue(1, 32'h4040_0000, 32'h4000_0000, 3'b100, 0, "fmax_3_2");
      issue(3, 32'h8000_0000, 32'h0000_0000, 3'b011, 0, "fmin_negzero");
      issue(2, 32'h8000_0000, 32'h0000_0000, 3'b000, 1, "feq_negzero");
      issue(1, 32'hC000_0000, 32'hC040_0000, 3'b100, 0, "fmax_neg");
   endtask

   task automatic test_invalid_op();
      issue(3, 32'h1234_5678, 32'h8765_4321, 3'b110, 0, "invalid_op");
      issue(0, 32'h3F80_0000, 32'h3F80_0000, 3'b000, 0, "feq_after_invalid");
   endtask

   task automatic test_backpressure();
      logic [32:0] exp;
      int g;
      load_slot(1, 32'h4120_0000, 32'h4110_0000, 3'b100);
      load_slot(2, 32'h0000_0001, 32'h8000_0001, 3'b010);
      exp = ref_eval(3'b100, 32'h4120_0000, 32'h4110_0000);
      req_valid  = 4'b0010;
      resp_ready = 1'b0;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_grant: got req_ready=%b, expected 0010", req_ready);
      end
      cyc();
      req_valid = 4'b0101;
      cyc();
      for (int k = 0; k < 10; k++) begin
         #1;
         checks++;
         if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== exp[31:0] ||
             resp_err !== exp[32] || req_ready !== 4'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%b id=%0d data=%h err=%b ready=%b, expected 1 1 %h %b 0000",
                     k, resp_valid, resp_id, resp_data, resp_err, req_ready, exp[31:0], exp[32]);
         end
         cyc();
      end
      resp_ready = 1'b1;
      cyc();
      model_ptr = 2;
      g = model_grant(4'b0101, model_ptr);
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== (4'b0001 << g)) begin
         errors++;
         $display("FAIL bp_release: got v=%b ready=%b, expected 0 %b", resp_valid, req_ready,
                  4'b0001 << g);
      end
      cyc();
      req_valid = '0;
      cyc();
      exp = ref_eval(3'b010, 32'h0000_0001, 32'h8000_0001);
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(g) || resp_data !== exp[31:0]) begin
         errors++;
         $display("FAIL bp_next_resp: got v=%b id=%0d data=%h, expected 1 %0d %h",
                  resp_valid, resp_id, resp_data, g, exp[31:0]);
      end
      cyc();
      model_ptr = (g + 1) % 4;
   endtask

   task automatic test_reset_mid_resp();
      load_slot(1, 32'h3F80_0000, 32'h4000_0000, 3'b001);
      req_valid  = 4'b0010;
      resp_ready = 1'b0;
      cyc();
      req_valid = '0;
      cyc();
      cyc();
      #1;
      checks++;
      if (resp_valid !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre: got resp_valid=%b, expected 1", resp_valid);
      end
      RESET = 1'b1;
      cyc();
      RESET = 1'b0;
      #1;
      checks++;
      if ({resp_valid, busy, resp_id, resp_data, resp_err} !== '0) begin
         errors++;
         $display("FAIL rst_mid_drop: got v=%b busy=%b id=%0d data=%h err=%b, expected all 0",
                  resp_valid, busy, resp_id, resp_data, resp_err);
      end
      req_valid = 4'hF;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rst_mid_ptr: got req_ready=%b, expected 0001", req_ready);
      end
      req_valid = '0;
      RESET     = 1'b1;
      cyc();
      RESET     = 1'b0;
      model_ptr = 0;
   endtask

   task automatic test_round_robin();
      int          order [5] = '{0, 1, 2, 3, 0};
      logic [32:0] exp_q [$];
      int          id_q  [$];
      logic [32:0] e;
      int          ngrants = 0, nresp = 0, last = 0, g, eid;
      for (int i = 0; i < 4; i++) begin
         load_slot(i, $urandom, $urandom, 3'($urandom_range(0, 4)));
      end
      req_valid  = 4'hF;
      resp_ready = 1'b1;
      for (int c = 0; c < 40 && nresp < 5; c++) begin
         #1;
         if (req_ready !== 4'b0) begin
            g = model_grant(4'hF, model_ptr);
            checks++;
            if (ngrants >= 5 || req_ready !== (4'b0001 << order[ngrants]) ||
                req_ready !== (4'b0001 << g) || (ngrants > 0 && c - last != 3)) begin
               errors++;
               $display("FAIL rr_grant[%0d]: got ready=%b gap=%0d, expected %b gap=3",
                        ngrants, req_ready, c - last, 4'b0001 << g);
            end
            id_q.push_back(g);
            exp_q.push_back(ref_eval(req_op[3*g +: 3], req_a[32*g +: 32], req_b[32*g +: 32]));
            model_ptr = (g + 1) % 4;
            last = c;
            ngrants++;
         end
         if (resp_valid === 1'b1 && id_q.size() > 0) begin
            eid = id_q.pop_front();
            e   = exp_q.pop_front();
            checks++;
            if (resp_id !== 2'(eid) || resp_data !== e[31:0] || resp_err !== e[32]) begin
               errors++;
               $display("FAIL rr_resp[%0d]: got id=%0d data=%h err=%b, expected %0d %h %b",
                        nresp, resp_id, resp_data, resp_err, eid, e[31:0], e[32]);
            end
            nresp++;
         end
         cyc();
         if (ngrants >= 5) req_valid = '0;
      end
      checks++;
      if (nresp != 5 || ngrants != 5) begin
         errors++;
         $display("FAIL rr_timeout: got grants=%0d responses=%0d, expected 5 5", ngrants, nresp);
      end
      req_valid = '0;
      cyc();
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int t = 0; t < 40; t++) begin
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = a;
            1:       b = a ^ 32'h8000_0000;
            2:       b = {a[31:8], 8'($urandom)};
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         issue(int'($urandom_range(0, 3)), a, b, 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_minmax();
      test_invalid_op();
      test_backpressure();
      test_reset_mid_resp();
      test_round_robin();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
